// File: rtl/diaosi_types_pkg.sv
// Shared types for the diaosi memory-side blocks: arbiter FSM states and
// the encoding of the RAM status bus.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE_DIAOSI,
    ARB_IREQ_DIAOSI,
    ARB_DREQ_DIAOSI
  } arb_state_t;

  typedef enum logic [1:0] {
    FREE_DIAOSI   = 2'd0,
    BUSY_DIAOSI   = 2'd1,
    ACCESS_DIAOSI = 2'd2,
    ERROR_DIAOSI  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_arb_timer.sv
// Clear/enable wait counter; expire is high while the count sits at TIMEOUT-1.
module diaosi_arb_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/diaosi_mem_arbiter.sv
// Shares one RAM port between instruction fetch and data memory: data has
// priority, a streak counter bounds fetch starvation, a timer aborts stuck accesses.
module diaosi_mem_arbiter
  import diaosi_types_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  ramstate_t     rs;
  logic          dpend;
  logic          icomplete, dcomplete;
  logic          fault;
  logic          tmr_en, tmr_expire;

  assign rs    = ramstate_t'(ramstate);
  assign dpend = dREN || dWEN;
  assign iwait = iREN && !icomplete;
  assign dwait = dpend && !dcomplete;

  diaosi_arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (CLK),
    .rst   (RST),
    .clear (state == ARB_IDLE_DIAOSI),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB_IDLE_DIAOSI;
      streak <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      if (fault) err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    icomplete  = 1'b0;
    dcomplete  = 1'b0;
    iload      = '0;
    dload      = '0;
    fault      = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      ARB_IDLE_DIAOSI: begin
        if (dpend && (!iREN || (streak < STREAK_LIM))) state_nxt = ARB_DREQ_DIAOSI;
        else if (iREN)                                 state_nxt = ARB_IREQ_DIAOSI;
      end
      ARB_IREQ_DIAOSI: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        // A dropped request abandons the transaction before any completion check.
        if (!iREN) begin
          state_nxt = ARB_IDLE_DIAOSI;
        end else if (rs == ACCESS_DIAOSI || rs == ERROR_DIAOSI || tmr_expire) begin
          icomplete  = 1'b1;
          fault      = (rs != ACCESS_DIAOSI);
          iload      = fault ? ERR_WORD : ramload;
          state_nxt  = ARB_IDLE_DIAOSI;
          streak_nxt = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ARB_DREQ_DIAOSI: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dpend) begin
          state_nxt = ARB_IDLE_DIAOSI;
        end else if (rs == ACCESS_DIAOSI || rs == ERROR_DIAOSI || tmr_expire) begin
          dcomplete = 1'b1;
          fault     = (rs != ACCESS_DIAOSI);
          dload     = fault ? ERR_WORD : ramload;
          state_nxt = ARB_IDLE_DIAOSI;
          if (!iREN)                     streak_nxt = '0;
          else if (streak != STREAK_LIM) streak_nxt = streak + 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE_DIAOSI;
    endcase
  end

endmodule

// File: tb/tb_diaosi_mem_arbiter.sv
// Directed bench for diaosi_mem_arbiter: per-cycle vector table plus
// hand-written timeout, reset and request-drop sequences.
module tb_diaosi_mem_arbiter;

  localparam logic        H  = 1'b1;
  localparam logic        L  = 1'b0;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [1:0]  FR = 2'd0;
  localparam logic [1:0]  BS = 2'd1;
  localparam logic [1:0]  AC = 2'd2;
  localparam logic [1:0]  ER = 2'd3;
  localparam logic [31:0] EW = 32'hBAD1BAD1;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] rload;
    logic [1:0]  rs;
    logic        e_iwait;
    logic        e_dwait;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic        e_err;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_vec = 0;
  int n_bad = 0;

  vec_t vecs[28];

  always #5 CLK = ~CLK;

  diaosi_mem_arbiter #(
    .STREAK_MAX(4),
    .TIMEOUT   (64),
    .ERR_WORD  (32'hBAD1BAD1)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .err     (err)
  );

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = L; dREN = L; dWEN = L;
    iaddr = Z; daddr = Z; dstore = Z; ramload = Z; ramstate = FR;
  endtask

  initial begin
    int stalls;

    // scenario A: fetch alone, ACCESS after two BUSY cycles
    vecs[0]  = '{H,32'h100,L,L,Z,Z,Z,FR,            H,L,L,L,Z,Z,Z,Z,L};
    vecs[1]  = '{H,32'h100,L,L,Z,Z,Z,BS,            H,L,H,L,32'h100,Z,Z,Z,L};
    vecs[2]  = '{H,32'h100,L,L,Z,Z,Z,BS,            H,L,H,L,32'h100,Z,Z,Z,L};
    vecs[3]  = '{H,32'h100,L,L,Z,Z,32'h8C220004,AC, L,L,H,L,32'h100,Z,32'h8C220004,Z,L};
    vecs[4]  = '{L,Z,L,L,Z,Z,Z,FR,                  L,L,L,L,Z,Z,Z,Z,L};
    // scenario B: write and fetch together, data wins, bubble, then fetch
    vecs[5]  = '{H,32'h200,L,H,32'h300,32'h55,Z,FR,            H,H,L,L,Z,Z,Z,Z,L};
    vecs[6]  = '{H,32'h200,L,H,32'h300,32'h55,32'hAAAA0001,AC, H,L,L,H,32'h300,32'h55,Z,32'hAAAA0001,L};
    vecs[7]  = '{H,32'h200,L,L,Z,Z,Z,FR,                       H,L,L,L,Z,Z,Z,Z,L};
    vecs[8]  = '{H,32'h200,L,L,Z,Z,32'h11112222,AC,            L,L,H,L,32'h200,Z,32'h11112222,Z,L};
    vecs[9]  = '{L,Z,L,L,Z,Z,Z,FR,                             L,L,L,L,Z,Z,Z,Z,L};
    // scenario C: reads back-to-back with fetch held; 4 data grants then fetch
    vecs[10] = '{H,32'h240,H,L,32'h340,Z,32'hC0,AC, H,H,L,L,Z,Z,Z,Z,L};
    vecs[11] = '{H,32'h240,H,L,32'h340,Z,32'hC1,AC, H,L,H,L,32'h340,Z,Z,32'hC1,L};
    vecs[12] = '{H,32'h240,H,L,32'h340,Z,32'hC2,AC, H,H,L,L,Z,Z,Z,Z,L};
    vecs[13] = '{H,32'h240,H,L,32'h340,Z,32'hC3,AC, H,L,H,L,32'h340,Z,Z,32'hC3,L};
    vecs[14] = '{H,32'h240,H,L,32'h340,Z,32'hC4,AC, H,H,L,L,Z,Z,Z,Z,L};
    vecs[15] = '{H,32'h240,H,L,32'h340,Z,32'hC5,AC, H,L,H,L,32'h340,Z,Z,32'hC5,L};
    vecs[16] = '{H,32'h240,H,L,32'h340,Z,32'hC6,AC, H,H,L,L,Z,Z,Z,Z,L};
    vecs[17] = '{H,32'h240,H,L,32'h340,Z,32'hC7,AC, H,L,H,L,32'h340,Z,Z,32'hC7,L};
    vecs[18] = '{H,32'h240,H,L,32'h340,Z,32'hC8,AC, H,H,L,L,Z,Z,Z,Z,L};
    vecs[19] = '{H,32'h240,H,L,32'h340,Z,32'hC9,AC, L,H,H,L,32'h240,Z,32'hC9,Z,L};
    vecs[20] = '{H,32'h240,H,L,32'h340,Z,32'hCA,AC, H,H,L,L,Z,Z,Z,Z,L};
    vecs[21] = '{H,32'h240,H,L,32'h340,Z,32'hCB,AC, H,L,H,L,32'h340,Z,Z,32'hCB,L};
    vecs[22] = '{L,Z,L,L,Z,Z,Z,FR,                  L,L,L,L,Z,Z,Z,Z,L};
    // scenario D: ERROR during a data read, then a normal fetch
    vecs[23] = '{L,Z,H,L,32'h400,Z,Z,FR,            L,H,L,L,Z,Z,Z,Z,L};
    vecs[24] = '{L,Z,H,L,32'h400,Z,32'h12345678,ER, L,L,H,L,32'h400,Z,Z,EW,L};
    vecs[25] = '{H,32'h500,L,L,Z,Z,Z,FR,            H,L,L,L,Z,Z,Z,Z,H};
    vecs[26] = '{H,32'h500,L,L,Z,Z,32'h0F0F0F0F,AC, L,L,H,L,32'h500,Z,32'h0F0F0F0F,Z,H};
    vecs[27] = '{L,Z,L,L,Z,Z,Z,FR,                  L,L,L,L,Z,Z,Z,Z,H};

    idle_inputs();
    RST = H;
    cyc();
    cyc();
    chk("rst_ramREN", 0, {31'b0, ramREN}, 32'h0);
    chk("rst_ramWEN", 0, {31'b0, ramWEN}, 32'h0);
    chk("rst_ramaddr", 0, ramaddr, Z);
    chk("rst_err", 0, {31'b0, err}, 32'h0);
    chk("rst_iload", 0, iload, Z);
    RST = L;

    for (int i = 0; i < 28; i++) begin
      iREN = vecs[i].iren;  iaddr = vecs[i].iaddr;
      dREN = vecs[i].dren;  dWEN = vecs[i].dwen;
      daddr = vecs[i].daddr; dstore = vecs[i].dstore;
      ramload = vecs[i].rload; ramstate = vecs[i].rs;
      #1;
      chk("iwait",    i, {31'b0, iwait},  {31'b0, vecs[i].e_iwait});
      chk("dwait",    i, {31'b0, dwait},  {31'b0, vecs[i].e_dwait});
      chk("ramREN",   i, {31'b0, ramREN}, {31'b0, vecs[i].e_ren});
      chk("ramWEN",   i, {31'b0, ramWEN}, {31'b0, vecs[i].e_wen});
      chk("ramaddr",  i, ramaddr,  vecs[i].e_addr);
      chk("ramstore", i, ramstore, vecs[i].e_store);
      chk("iload",    i, iload,    vecs[i].e_iload);
      chk("dload",    i, dload,    vecs[i].e_dload);
      chk("err",      i, {31'b0, err}, {31'b0, vecs[i].e_err});
      cyc();
    end

    // reset clears sticky err
    RST = H;
    cyc();
    RST = L;
    chk("err_cleared", 0, {31'b0, err}, 32'h0);

    // stuck BUSY: forced completion in owned cycle 64
    iREN = H; iaddr = 32'h600; ramstate = BS; ramload = 32'h33;
    #1;
    chk("to_idle_iwait", 0, {31'b0, iwait}, 32'h1);
    cyc();
    stalls = 0;
    for (int k = 1; k < 64; k++) begin
      #1;
      if (iwait && ramREN) stalls++;
      cyc();
    end
    chk("to_stall_cycles", 0, stalls, 63);
    #1;
    chk("to_iwait", 64, {31'b0, iwait}, 32'h0);
    chk("to_iload", 64, iload, EW);
    chk("to_err_before_edge", 64, {31'b0, err}, 32'h0);
    cyc();
    iREN = L; ramstate = FR;
    #1;
    chk("to_err", 65, {31'b0, err}, 32'h1);
    for (int k = 0; k < 3; k++) cyc();
    chk("to_err_sticky", 68, {31'b0, err}, 32'h1);

    // reset in the middle of a data write
    dWEN = H; daddr = 32'h700; dstore = 32'h99; ramstate = BS;
    #1;
    chk("rstmid_idle_dwait", 0, {31'b0, dwait}, 32'h1);
    cyc();
    chk("rstmid_ramWEN", 1, {31'b0, ramWEN}, 32'h1);
    chk("rstmid_ramstore", 1, ramstore, 32'h99);
    RST = H;
    cyc();
    chk("rstmid_ramWEN_drop", 2, {31'b0, ramWEN}, 32'h0);
    chk("rstmid_ramREN_drop", 2, {31'b0, ramREN}, 32'h0);
    chk("rstmid_err", 2, {31'b0, err}, 32'h0);
    chk("rstmid_ramaddr", 2, ramaddr, Z);
    RST = L; dWEN = L;
    cyc();

    // ACCESS on the expiry cycle wins over the timeout
    iREN = H; iaddr = 32'h800; ramstate = BS;
    cyc();
    for (int k = 1; k < 64; k++) cyc();
    ramstate = AC; ramload = 32'h77;
    #1;
    chk("aw_iwait", 64, {31'b0, iwait}, 32'h0);
    chk("aw_iload", 64, iload, 32'h77);
    cyc();
    iREN = L; ramstate = FR;
    #1;
    chk("aw_err", 65, {31'b0, err}, 32'h0);

    // data read dropped mid-transaction: no completion, back through IDLE
    dREN = H; daddr = 32'h900; ramstate = BS; ramload = 32'h5A5A;
    cyc();
    chk("drop_ramREN", 1, {31'b0, ramREN}, 32'h1);
    chk("drop_dwait", 1, {31'b0, dwait}, 32'h1);
    dREN = L;
    #1;
    chk("drop_ramREN_low", 1, {31'b0, ramREN}, 32'h0);
    chk("drop_dload", 1, dload, Z);
    cyc();
    dREN = H; ramstate = AC;
    #1;
    chk("drop_idle_dwait", 2, {31'b0, dwait}, 32'h1);
    chk("drop_idle_ramREN", 2, {31'b0, ramREN}, 32'h0);
    cyc();
    chk("drop_redo_dwait", 3, {31'b0, dwait}, 32'h0);
    chk("drop_redo_dload", 3, dload, 32'h5A5A);
    chk("drop_redo_err", 3, {31'b0, err}, 32'h0);
    idle_inputs();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
